// File: rtl/mig_wr_frame_sched.sv
// mig_wr_frame_sched: upstream burst scheduler for the MIG write controller.
// Drains an FWFT pixel FIFO, slices each frame into bursts of BURST_LEN words,
// issues one-cycle wr_req pulses with address/length, and streams FIFO words.
// Optional build macro: MIG_WR_PINGPONG_EN (alternate frames between
// BASE_ADDR0 and BASE_ADDR1 and report the completed buffer on frame_sel).
module mig_wr_frame_sched #(
    parameter int          BURST_LEN   = 64,
    parameter int          FRAME_WORDS = 115200,
    parameter int          ADDR_STEP   = 8,
    parameter logic [27:0] BASE_ADDR0  = 28'h0000000,
    parameter logic [27:0] BASE_ADDR1  = 28'h0800000
) (
    input  logic         ui_clk,
    input  logic         rst_n,
    input  logic         init_calib_complete,
    input  logic [9:0]   fifo_rd_count,
    input  logic [127:0] fifo_rd_data,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    output logic         wr_req,
    output logic [27:0]  wr_req_addr,
    output logic [15:0]  wr_length,
    output logic [127:0] wr_data,
    input  logic         wr_busy,
    input  logic         wr_data_valid,
    input  logic         wr_done,
    output logic         frame_done,
    output logic         frame_sel,
    output logic         err_underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_REQ,
        ST_BURST,
        ST_UPDATE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_words_done;
    logic [27:0] r_next_addr;
    logic [27:0] r_wr_req_addr;
    logic [15:0] r_wr_length;
    logic        r_err_underrun;

    logic [31:0] w_rem;
    logic [31:0] w_this_len;
    logic [31:0] w_words_sum;
    logic        w_data_ready;
    logic        w_frame_end;
    logic        w_latch;
    logic        w_update;
    logic        w_next_sel;
    logic [27:0] w_next_base;

    // Size of the upcoming burst: a full burst, or whatever is left of the frame.
    assign w_rem        = 32'(FRAME_WORDS) - r_words_done;
    assign w_this_len   = (w_rem < 32'(BURST_LEN)) ? w_rem : 32'(BURST_LEN);
    assign w_data_ready = ({22'd0, fifo_rd_count} >= w_this_len) && !wr_busy;
    assign w_words_sum  = r_words_done + {16'd0, r_wr_length};
    assign w_frame_end  = (w_words_sum >= 32'(FRAME_WORDS));
    assign w_next_base  = w_next_sel ? BASE_ADDR1 : BASE_ADDR0;

`ifdef MIG_WR_PINGPONG_EN
    logic r_cur_sel;
    logic r_frame_sel;

    // Buffer toggle: remember the finished buffer, then switch to the other one.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            r_cur_sel   <= 1'b0;
            r_frame_sel <= 1'b0;
        end else if (w_update && w_frame_end) begin
            r_frame_sel <= r_cur_sel;
            r_cur_sel   <= ~r_cur_sel;
        end
    end

    assign w_next_sel = ~r_cur_sel;
    assign frame_sel  = r_frame_sel;
`else
    // Single buffer: every frame restarts at BASE_ADDR0.
    assign w_next_sel = 1'b0;
    assign frame_sel  = 1'b0;
`endif

    // State register.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the per-state strobes. A busy controller during
    // REQ holds the request back so wr_req never overlaps wr_busy.
    always_comb begin
        w_state_next = r_state;
        wr_req       = 1'b0;
        w_latch      = 1'b0;
        w_update     = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init_calib_complete) begin
                    w_state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (w_data_ready) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!wr_busy) begin
                    wr_req       = 1'b1;
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wr_done) begin
                    w_state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_update     = 1'b1;
                frame_done   = w_frame_end;
                w_state_next = ST_WAIT_DATA;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: latch request fields, advance frame position, flag underrun.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            r_words_done   <= 32'd0;
            r_next_addr    <= BASE_ADDR0;
            r_wr_req_addr  <= 28'd0;
            r_wr_length    <= 16'd0;
            r_err_underrun <= 1'b0;
        end else begin
            if (w_latch) begin
                r_wr_req_addr <= r_next_addr;
                r_wr_length   <= w_this_len[15:0];
            end
            if (w_update) begin
                if (w_frame_end) begin
                    r_words_done <= 32'd0;
                    r_next_addr  <= w_next_base;
                end else begin
                    r_words_done <= w_words_sum;
                    r_next_addr  <= r_next_addr + 28'({16'd0, r_wr_length} * 32'(ADDR_STEP));
                end
            end
            if (fifo_rd_en && fifo_empty) begin
                r_err_underrun <= 1'b1;
            end
        end
    end

    assign fifo_rd_en   = wr_data_valid && (r_state == ST_BURST);
    assign wr_data      = fifo_rd_data;
    assign wr_req_addr  = r_wr_req_addr;
    assign wr_length    = r_wr_length;
    assign err_underrun = r_err_underrun;

endmodule

// File: tb/tb_mig_wr_frame_sched.sv
// Testbench for mig_wr_frame_sched: directed steps plus randomized bursts,
// checked against a frame-offset reference model.
module tb_mig_wr_frame_sched;

    localparam int          BL = 4;
    localparam int          FW = 10;
    localparam int          AS = 8;
    localparam logic [27:0] B0 = 28'h000;
    localparam logic [27:0] B1 = 28'h100;
`ifdef MIG_WR_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic         ui_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init_calib_complete = 1'b0;
    logic [9:0]   fifo_rd_count = 10'd0;
    logic [127:0] fifo_rd_data = '0;
    logic         fifo_empty = 1'b0;
    logic         fifo_rd_en;
    logic         wr_req;
    logic [27:0]  wr_req_addr;
    logic [15:0]  wr_length;
    logic [127:0] wr_data;
    logic         wr_busy = 1'b0;
    logic         wr_data_valid = 1'b0;
    logic         wr_done = 1'b0;
    logic         frame_done;
    logic         frame_sel;
    logic         err_underrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the frame, frame index, flags.
    int   m_words = 0;
    int   m_frame = 0;
    logic m_sel   = 1'b0;
    logic m_err   = 1'b0;

    mig_wr_frame_sched #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .ADDR_STEP   (AS),
        .BASE_ADDR0  (B0),
        .BASE_ADDR1  (B1)
    ) dut (
        .ui_clk              (ui_clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .fifo_rd_count       (fifo_rd_count),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_empty          (fifo_empty),
        .fifo_rd_en          (fifo_rd_en),
        .wr_req              (wr_req),
        .wr_req_addr         (wr_req_addr),
        .wr_length           (wr_length),
        .wr_data             (wr_data),
        .wr_busy             (wr_busy),
        .wr_data_valid       (wr_data_valid),
        .wr_done             (wr_done),
        .frame_done          (frame_done),
        .frame_sel           (frame_sel),
        .err_underrun        (err_underrun)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    function automatic logic [27:0] m_base(input int f);
        return (PP && (f % 2 == 1)) ? B1 : B0;
    endfunction

    function automatic int m_len();
        return ((FW - m_words) < BL) ? (FW - m_words) : BL;
    endfunction

    // Wait (bounded) for a request and compare it to the model's next burst.
    task automatic wait_req(output bit ok);
        logic [27:0] exp_addr;
        logic [15:0] exp_len;
        exp_addr = m_base(m_frame) + 28'(m_words * AS);
        exp_len  = 16'(m_len());
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk1("req_seen", ok, 1'b1);
        if (ok) begin
            chkw("req_addr", 128'(wr_req_addr), 128'(exp_addr));
            chkw("req_len", 128'(wr_length), 128'(exp_len));
            $display("req addr=%0h len=%0d frame=%0d", wr_req_addr, wr_length, m_frame);
        end
    endtask

    // One complete burst: request, data phase with stalls, update cycle.
    task automatic do_burst(input int ur_idx, input int max_stall);
        bit           ok;
        int           len;
        bit           last_of_frame;
        logic [127:0] d;
        len = m_len();
        wait_req(ok);
        if (!ok) return;
        tick();
        chk1("req_one_cycle", wr_req, 1'b0);
        for (int i = 0; i < len; i++) begin
            int st;
            st = int'($urandom_range(max_stall, 0));
            for (int s = 0; s < st; s++) begin
                wr_data_valid = 1'b0;
                #1;
                chk1("rd_en_idle", fifo_rd_en, 1'b0);
                tick();
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            fifo_rd_data  = d;
            wr_data_valid = 1'b1;
            wr_done       = (i == len - 1);
            fifo_empty    = (i == ur_idx);
            #1;
            chk1("rd_en", fifo_rd_en, 1'b1);
            chkw("wr_data", wr_data, d);
            if (i == ur_idx) m_err = 1'b1;
            tick();
        end
        wr_data_valid = 1'b0;
        wr_done       = 1'b0;
        fifo_empty    = 1'b0;
        last_of_frame = (m_words + len == FW);
        #1;
        chk1("frame_done", frame_done, last_of_frame);
        chk1("req_in_update", wr_req, 1'b0);
        if (last_of_frame) begin
            m_sel   = PP && (m_frame % 2 == 1);
            m_words = 0;
            m_frame++;
        end else begin
            m_words += len;
        end
        tick();
        chk1("frame_done_pulse", frame_done, 1'b0);
        chk1("frame_sel", frame_sel, m_sel);
        chk1("err_underrun", err_underrun, m_err);
    endtask

    initial begin
        bit ok;
        logic [127:0] d;

        // Reset state
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        fifo_rd_count = 10'd20;
        repeat (3) tick();
        chk1("rst_wr_req", wr_req, 1'b0);
        chkw("rst_addr", 128'(wr_req_addr), 128'(0));
        chkw("rst_len", 128'(wr_length), 128'(0));
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_frame_sel", frame_sel, 1'b0);
        chk1("rst_underrun", err_underrun, 1'b0);
        chk1("rst_rd_en", fifo_rd_en, 1'b0);

        // Calibration gate
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("calib_gate", wr_req, 1'b0);
        end
        init_calib_complete = 1'b1;

        // Frame 1: three bursts (4,4,2)
        do_burst(-1, 0);
        do_burst(-1, 1);
        do_burst(-1, 1);

        // Threshold: 3 words available for a 4-word burst
        fifo_rd_count = 10'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("thresh_hold", wr_req, 1'b0);
        end
        fifo_rd_count = 10'd4;
        tick();
        chk1("thresh_next", wr_req, 1'b1);
        do_burst(-1, 0);

        // Busy gating
        fifo_rd_count = 10'd20;
        wr_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("busy_hold", wr_req, 1'b0);
        end
        wr_busy = 1'b0;
        do_burst(-1, 0);

        // Underrun on the final burst of frame 2
        do_burst(1, 0);

        // Randomized bursts spanning several frames
        for (int n = 0; n < 30; n++) begin
            fifo_rd_count = 10'($urandom_range(1023, BL));
            init_calib_complete = 1'($urandom_range(1, 0));
            if ($urandom_range(3, 0) == 0) begin
                wr_busy = 1'b1;
                for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
                    tick();
                    chk1("rand_busy_hold", wr_req, 1'b0);
                end
                wr_busy = 1'b0;
            end
            do_burst(-1, 2);
        end

        // Reset mid-burst
        init_calib_complete = 1'b1;
        fifo_rd_count = 10'd20;
        wait_req(ok);
        tick();
        d = {$urandom, $urandom, $urandom, $urandom};
        fifo_rd_data = d;
        wr_data_valid = 1'b1;
        tick();
        wr_data_valid = 1'b0;
        rst_n = 1'b0;
        init_calib_complete = 1'b0;
        tick();
        wr_data_valid = 1'b1;
        #1;
        chk1("mid_rst_rd_en", fifo_rd_en, 1'b0);
        wr_data_valid = 1'b0;
        chk1("mid_rst_wr_req", wr_req, 1'b0);
        chkw("mid_rst_addr", 128'(wr_req_addr), 128'(0));
        chkw("mid_rst_len", 128'(wr_length), 128'(0));
        chk1("mid_rst_frame_done", frame_done, 1'b0);
        chk1("mid_rst_frame_sel", frame_sel, 1'b0);
        chk1("mid_rst_underrun", err_underrun, 1'b0);
        rst_n = 1'b1;
        m_words = 0;
        m_frame = 0;
        m_sel   = 1'b0;
        m_err   = 1'b0;
        repeat (3) begin
            tick();
            chk1("post_rst_idle", wr_req, 1'b0);
        end
        init_calib_complete = 1'b1;
        do_burst(-1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mig_wr_frame_sched.md
Name: mig_wr_frame_sched

Overview:
- Upstream scheduler for the MIG burst write controller.
- Drains a first-word-fall-through (FWFT) pixel FIFO, 128-bit words, read side on ui_clk.
- Chops each video frame into bursts. For each burst it issues wr_req/wr_req_addr/wr_length and streams FIFO words as wr_data.
- Tracks the frame position, wraps at frame end, and reports frame completion and FIFO underrun.

Parameters:
- BURST_LEN, 64: 128-bit words per burst request; must be ≤ FIFO depth.
- FRAME_WORDS, 115200: 128-bit words per frame (1280x720x16b/128).
- ADDR_STEP, 8: address increment per 128-bit word (4:1 clock ratio, BL8).
- BASE_ADDR0, 28'h0000000: frame buffer 0 base.
- BASE_ADDR1, 28'h0800000: frame buffer 1 base (used only with PINGPONG_EN).

Ports:
- ui_clk  in  1  MIG user clock
- rst_n  in  1  synchronous active-low reset
- init_calib_complete  in  1  DDR calibration done
- fifo_rd_count  in  10  FIFO read-side occupancy in words
- fifo_rd_data  in  128  FWFT head word
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop FIFO head
- wr_req  out  1  one-cycle burst request to the write controller
- wr_req_addr  out  28  burst start address
- wr_length  out  16  burst length in words
- wr_data  out  128  write data (= fifo_rd_data)
- wr_busy  in  1  write controller busy
- wr_data_valid  in  1  write controller accepted wr_data this cycle
- wr_done  in  1  last word of the burst accepted
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes
- frame_sel  out  1  buffer index of the most recently completed frame
- err_underrun  out  1  sticky flag: word accepted while the FIFO was empty

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0; cur_base = BASE_ADDR0; next address = BASE_ADDR0.
- Reset asserted mid-burst aborts immediately and returns to IDLE with the reset values above; no frame_done is produced.
- Burst size: rem = FRAME_WORDS - words_done; this_len = min(BURST_LEN, rem). All arithmetic is 32-bit internally; wr_length is the lower 16 bits.
- FSM states and transitions:
  - IDLE: wait for init_calib_complete=1, then go to WAIT_DATA.
  - WAIT_DATA: compute this_len. When fifo_rd_count ≥ this_len and wr_busy=0:
    - latch wr_req_addr = next address and wr_length = this_len;
    - go to REQ.
  - REQ: wr_req=1 for exactly one cycle, then go to BURST.
  - BURST: wr_req=0. Exit on wr_done (sampled at the same edge as the final wr_data_valid) and go to UPDATE.
  - UPDATE (one cycle):
    - words_done += wr_length; next address += wr_length*ADDR_STEP.
    - If words_done reaches FRAME_WORDS: words_done=0; next address = base of the next frame; frame_done=1 for this cycle; frame_sel = buffer just finished.
    - Go to WAIT_DATA.
- Hold rules:
  - wr_req_addr and wr_length are held stable from REQ until the next latch.
  - wr_req is never asserted while wr_busy=1.
- Data path:
  - wr_data = fifo_rd_data, combinational.
  - fifo_rd_en = wr_data_valid && state==BURST.
- Error handling: if fifo_rd_en && fifo_empty, set err_underrun. It is cleared only by reset; the word is still counted.
- Latency:
  - Threshold met in WAIT_DATA → wr_req asserted 1 cycle later.
  - wr_done → next wr_req asserted no earlier than 3 cycles later (UPDATE, WAIT_DATA, REQ).
- Simultaneous events: init_calib_complete deasserting outside IDLE is ignored; only reset returns the FSM to IDLE.
- Boundary: FRAME_WORDS not a multiple of BURST_LEN gives a short final burst of (FRAME_WORDS mod BURST_LEN) words; the address still advances contiguously.

Optional Feature:
- Macro: MIG_WR_PINGPONG_EN.
- Defined:
  - Frames alternate between BASE_ADDR0 and BASE_ADDR1; cur_base toggles in UPDATE on frame completion.
  - frame_sel = index of the buffer just completed, updated with frame_done.
- Undefined:
  - Every frame starts at BASE_ADDR0.
  - frame_sel is tied to 0.

Test Plan (BURST_LEN=4, FRAME_WORDS=10, ADDR_STEP=8, BASE_ADDR1=28'h100):
- Calibration gate: init_calib_complete=0, fifo_rd_count=20 → wr_req stays 0. After calibration asserts → wr_req pulse with addr 0x000, length 4.
- Frame sequencing: 10 words supplied; the controller model accepts one word/cycle → requests are (0x000,4), (0x020,4), (0x040,2). frame_done pulses once, one cycle after the third wr_done.
- Threshold: fifo_rd_count=3 with this_len=4 → no wr_req. Count rises to 4 → wr_req the next cycle.
- Busy gating: wr_busy held 1 in WAIT_DATA with data available → no wr_req until wr_busy falls.
- Underrun and ping-pong: wr_data_valid asserted while fifo_empty=1 → err_underrun=1 and it stays 1.
  - With MIG_WR_PINGPONG_EN, the second frame's first request has addr 0x100.
  - frame_sel is 0 after frame 1 and 1 after frame 2.
- Reset mid-burst: rst_n=0 for 1 cycle during a burst → all outputs 0. After calibration, the next request is addr 0x000, length 4.
